// File: rtl/apb_slave_if.sv
// rtl/apb_slave_if.sv - APB bus signals between a master and the apb_slave completer
interface apb_slave_if;
   logic [31:0] PADDR;
   logic        PSELx;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   modport master (
      output PADDR, PSELx, PENABLE, PWRITE, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PSELx, PENABLE, PWRITE, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_slave.sv
// rtl/apb_slave.sv - APB completer with word-addressed register file, wait states and error response
module apb_slave #(
   parameter int          NUM_REGS       = 16,
   parameter int          WAIT_STATES    = 0,
   parameter logic [31:0] FORBIDDEN_ADDR = 32'h0000_CACA,
   localparam int         IDXW           = $clog2(NUM_REGS)
) (
   input  logic            i_clk,
   input  logic            i_reset,
   apb_slave_if.slave      apb,
   output logic            o_wr_en,
   output logic [IDXW-1:0] o_wr_idx,
   output logic [31:0]     o_wr_data,
   output logic [7:0]      o_err_count
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              write_q, write_d;
   logic              err_q, err_d;

   logic [31:0]       prdata_d;
   logic              pready_d;
   logic              pslverr_d;
   logic              wr_en_d;
   logic [IDXW-1:0]   wr_idx_d;
   logic [31:0]       wr_data_d;
   logic [7:0]        err_count_d;

   logic [31:0]       regs [NUM_REGS];

   logic              setup;
   logic              setup_err;
   logic [31:0]       setup_rd;
   logic [31:0]       acc_rd;

   function automatic logic addr_err(input logic [31:0] a);
      return (a[1:0] != 2'b00)
          || ({2'b00, a[31:2]} >= 32'(NUM_REGS))
          || (a == FORBIDDEN_ADDR);
   endfunction

   assign setup     = apb.PSELx && !apb.PENABLE;
   assign setup_err = addr_err(apb.PADDR);
   assign setup_rd  = regs[apb.PADDR[2 +: IDXW]];
   assign acc_rd    = regs[idx_q];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      wdata_d     = wdata_q;
      write_d     = write_q;
      err_d       = err_q;
      prdata_d    = apb.PRDATA;
      pready_d    = apb.PREADY;
      pslverr_d   = apb.PSLVERR;
      wr_en_d     = 1'b0;
      wr_idx_d    = o_wr_idx;
      wr_data_d   = o_wr_data;
      err_count_d = o_err_count;

      case (state_q)
         IDLE, DONE: begin
            state_d   = IDLE;
            prdata_d  = 32'h0;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            if (setup) begin
               state_d = ACCESS;
               cnt_d   = 4'(WAIT_STATES);
               idx_d   = apb.PADDR[2 +: IDXW];
               wdata_d = apb.PWDATA;
               write_d = apb.PWRITE;
               err_d   = setup_err;
               // Zero-wait transfers answer in the very first access cycle.
               if (WAIT_STATES == 0) begin
                  pready_d  = 1'b1;
                  pslverr_d = setup_err;
                  prdata_d  = (setup_err || apb.PWRITE) ? 32'h0 : setup_rd;
               end
            end
         end

         ACCESS: begin
            if (!apb.PSELx) begin
               state_d   = IDLE;
               cnt_d     = 4'd0;
               prdata_d  = 32'h0;
               pready_d  = 1'b0;
               pslverr_d = 1'b0;
            end else if (apb.PREADY) begin
               if (apb.PENABLE) begin
                  state_d   = DONE;
                  prdata_d  = 32'h0;
                  pready_d  = 1'b0;
                  pslverr_d = 1'b0;
                  if (err_q) begin
                     if (o_err_count != 8'hFF) err_count_d = o_err_count + 8'd1;
                  end else if (write_q) begin
                     wr_en_d   = 1'b1;
                     wr_idx_d  = idx_q;
                     wr_data_d = wdata_q;
                  end
               end
            end else begin
               cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
               if (cnt_q <= 4'd1) begin
                  pready_d  = 1'b1;
                  pslverr_d = err_q;
                  prdata_d  = (err_q || write_q) ? 32'h0 : acc_rd;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         idx_q       <= '0;
         wdata_q     <= 32'h0;
         write_q     <= 1'b0;
         err_q       <= 1'b0;
         apb.PRDATA  <= 32'h0;
         apb.PREADY  <= 1'b0;
         apb.PSLVERR <= 1'b0;
         o_wr_en     <= 1'b0;
         o_wr_idx    <= '0;
         o_wr_data   <= 32'h0;
         o_err_count <= 8'h0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'h0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         wdata_q     <= wdata_d;
         write_q     <= write_d;
         err_q       <= err_d;
         apb.PRDATA  <= prdata_d;
         apb.PREADY  <= pready_d;
         apb.PSLVERR <= pslverr_d;
         o_wr_en     <= wr_en_d;
         o_wr_idx    <= wr_idx_d;
         o_wr_data   <= wr_data_d;
         o_err_count <= err_count_d;
         if (wr_en_d) regs[wr_idx_d] <= wr_data_d;
      end
   end

endmodule

// File: tb/tb_apb_slave.sv
// tb/tb_apb_slave.sv - directed bench for apb_slave across three parameter sets
module tb_apb_slave;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] paddr, pwdata;
   logic        penable, pwrite;
   logic [2:0]  psel;

   apb_slave_if bus0 ();
   apb_slave_if bus1 ();
   apb_slave_if bus2 ();

   assign bus0.PADDR = paddr;  assign bus0.PSELx = psel[0]; assign bus0.PENABLE = penable;
   assign bus0.PWRITE = pwrite; assign bus0.PWDATA = pwdata;
   assign bus1.PADDR = paddr;  assign bus1.PSELx = psel[1]; assign bus1.PENABLE = penable;
   assign bus1.PWRITE = pwrite; assign bus1.PWDATA = pwdata;
   assign bus2.PADDR = paddr;  assign bus2.PSELx = psel[2]; assign bus2.PENABLE = penable;
   assign bus2.PWRITE = pwrite; assign bus2.PWDATA = pwdata;

   logic [2:0]  pready_v, pslverr_v;
   logic [31:0] prdata_v [3];
   assign pready_v  = {bus2.PREADY, bus1.PREADY, bus0.PREADY};
   assign pslverr_v = {bus2.PSLVERR, bus1.PSLVERR, bus0.PSLVERR};
   assign prdata_v[0] = bus0.PRDATA;
   assign prdata_v[1] = bus1.PRDATA;
   assign prdata_v[2] = bus2.PRDATA;

   logic [2:0]  wr_en_v;
   logic [3:0]  idx0, idx1;
   logic [7:0]  idx2;
   logic [31:0] wd0, wd1, wd2;
   logic [7:0]  ec0, ec1, ec2;

   apb_slave #(.NUM_REGS(16), .WAIT_STATES(0)) u_d0 (
      .i_clk(clk), .i_reset(rst), .apb(bus0), .o_wr_en(wr_en_v[0]),
      .o_wr_idx(idx0), .o_wr_data(wd0), .o_err_count(ec0));
   apb_slave #(.NUM_REGS(16), .WAIT_STATES(3)) u_d1 (
      .i_clk(clk), .i_reset(rst), .apb(bus1), .o_wr_en(wr_en_v[1]),
      .o_wr_idx(idx1), .o_wr_data(wd1), .o_err_count(ec1));
   apb_slave #(.NUM_REGS(256), .WAIT_STATES(4)) u_d2 (
      .i_clk(clk), .i_reset(rst), .apb(bus2), .o_wr_en(wr_en_v[2]),
      .o_wr_idx(idx2), .o_wr_data(wd2), .o_err_count(ec2));

   int checks = 0;
   int errors = 0;

   logic [2:0]  snap_en;
   logic [7:0]  snap_idx  [3];
   logic [31:0] snap_data [3];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      snap_en      = wr_en_v;
      snap_idx[0]  = {4'b0, idx0};
      snap_idx[1]  = {4'b0, idx1};
      snap_idx[2]  = idx2;
      snap_data[0] = wd0;
      snap_data[1] = wd1;
      snap_data[2] = wd2;
   endtask

   // Returns at the negedge of the completing cycle, leaving the bus selected
   // so the next call can issue its setup cycle back-to-back.
   task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int waits);
      @(negedge clk);
      snap();
      psel    = 3'b000;
      psel[d] = 1'b1;
      paddr   = a;
      pwrite  = w;
      pwdata  = wd;
      penable = 1'b0;
      @(negedge clk);
      penable = 1'b1;
      waits   = 0;
      while (!pready_v[d] && waits < 40) begin
         @(negedge clk);
         waits++;
      end
      rd = prdata_v[d];
      er = pslverr_v[d];
   endtask

   task automatic idle();
      @(negedge clk);
      snap();
      psel    = 3'b000;
      penable = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          wt;

      rst = 1'b1; psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_pready",  {29'b0, pready_v}, 32'h0);
      chk("rst_pslverr", {29'b0, pslverr_v}, 32'h0);
      chk("rst_prdata0", prdata_v[0], 32'h0);
      chk("rst_wr_en",   {29'b0, wr_en_v}, 32'h0);
      chk("rst_errcnt",  {8'h0, ec0, ec1, ec2}, 32'h0);
      rst = 1'b0;

      xfer(0, 32'h08, 1'b1, 32'hDEADBEEF, rd, er, wt);
      chk("w08_waits", wt, 0);
      chk("w08_err", er, 0);
      xfer(0, 32'h08, 1'b0, 32'h0, rd, er, wt);
      chk("w08_wr_en", snap_en[0], 1);
      chk("w08_wr_idx", snap_idx[0], 2);
      chk("w08_wr_data", snap_data[0], 32'hDEADBEEF);
      chk("r08_data", rd, 32'hDEADBEEF);
      chk("r08_err", er, 0);
      chk("r08_waits", wt, 0);

      xfer(0, 32'h40, 1'b1, 32'h55AA55AA, rd, er, wt);
      chk("w40_err", er, 1);
      xfer(0, 32'h06, 1'b0, 32'h0, rd, er, wt);
      chk("w40_no_wr_en", snap_en[0], 0);
      chk("r06_data", rd, 32'h0);
      chk("r06_err", er, 1);
      xfer(0, 32'h00, 1'b0, 32'h0, rd, er, wt);
      chk("r00_unchanged", rd, 32'h0);
      chk("r00_err", er, 0);
      idle();
      chk("errcnt_two", ec0, 2);

      xfer(1, 32'h04, 1'b0, 32'h0, rd, er, wt);
      chk("ws3_waits", wt, 3);
      chk("ws3_data", rd, 32'h0);
      chk("ws3_err", er, 0);
      idle();

      xfer(2, 32'hCACA, 1'b1, 32'hCAFE, rd, er, wt);
      chk("forbid_err", er, 1);
      chk("ws4_waits", wt, 4);
      xfer(2, 32'h0C, 1'b1, 32'h12345678, rd, er, wt);
      chk("w0c_err", er, 0);
      idle();
      chk("w0c_wr_en", snap_en[2], 1);
      chk("w0c_wr_idx", snap_idx[2], 3);
      chk("w0c_wr_data", snap_data[2], 32'h12345678);

      @(negedge clk);
      psel = 3'b100; paddr = 32'h10; pwrite = 1'b1; pwdata = 32'hBAD0BAD0; penable = 1'b0;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      psel = 3'b000; penable = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort_no_wr_en", wr_en_v[2], 0);
      end
      chk("abort_pready", pready_v[2], 0);
      xfer(2, 32'h10, 1'b0, 32'h0, rd, er, wt);
      chk("abort_r10_data", rd, 32'h0);
      chk("abort_r10_err", er, 0);
      chk("abort_r10_waits", wt, 4);
      chk("d2_errcnt", ec2, 1);

      xfer(0, 32'h00, 1'b1, 32'h11111111, rd, er, wt);
      chk("b2b_w0_waits", wt, 0);
      xfer(0, 32'h04, 1'b1, 32'h22222222, rd, er, wt);
      chk("b2b_w0_en", snap_en[0], 1);
      chk("b2b_w0_idx", snap_idx[0], 0);
      chk("b2b_w1_waits", wt, 0);
      xfer(0, 32'h08, 1'b1, 32'h33333333, rd, er, wt);
      chk("b2b_w1_en", snap_en[0], 1);
      chk("b2b_w1_idx", snap_idx[0], 1);
      chk("b2b_w1_data", snap_data[0], 32'h22222222);
      chk("b2b_w2_waits", wt, 0);
      xfer(0, 32'h00, 1'b0, 32'h0, rd, er, wt);
      chk("b2b_w2_en", snap_en[0], 1);
      chk("b2b_w2_idx", snap_idx[0], 2);
      chk("b2b_w2_data", snap_data[0], 32'h33333333);
      chk("b2b_r0", rd, 32'h11111111);
      xfer(0, 32'h04, 1'b0, 32'h0, rd, er, wt);
      chk("b2b_r1", rd, 32'h22222222);
      xfer(0, 32'h08, 1'b0, 32'h0, rd, er, wt);
      chk("b2b_r2", rd, 32'h33333333);
      chk("b2b_r2_waits", wt, 0);
      idle();

      @(negedge clk);
      psel = 3'b001; paddr = 32'h04; pwrite = 1'b0; penable = 1'b0;
      @(negedge clk);
      penable = 1'b1;
      chk("mid_pready", pready_v[0], 1);
      chk("mid_prdata", prdata_v[0], 32'h22222222);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_pready", pready_v[0], 0);
      chk("rst_mid_prdata", prdata_v[0], 32'h0);
      chk("rst_mid_pslverr", pslverr_v[0], 0);
      chk("rst_mid_errcnt", ec0, 0);
      chk("rst_mid_wr_en", wr_en_v[0], 0);
      rst = 1'b0; psel = 3'b000; penable = 1'b0;
      xfer(0, 32'h04, 1'b0, 32'h0, rd, er, wt);
      chk("rst_regs_cleared", rd, 32'h0);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_slave.md
Name: apb_slave

Overview:
- APB completer: the responder end of the APB master's bus.
- Decodes PADDR into a word-addressed register file and services reads and writes.
- Inserts a configurable number of wait states and signals PSLVERR for illegal accesses.
- Exposes a write-notification strobe so local logic can react to register updates.

Parameters:
- NUM_REGS, 16, number of 32-bit registers; power of two, 2..256.
- WAIT_STATES, 0, extra ACCESS cycles before PREADY; 0..15.
- FORBIDDEN_ADDR, 32'h0000_CACA, byte address that always errors.

Ports:
- i_clk  in  1  APB clock; all logic on the rising edge.
- i_reset  in  1  Synchronous, active-high reset.
- PADDR  in  32  Byte address.
- PSELx  in  1  Slave select.
- PENABLE  in  1  Access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  32  Write data.
- PRDATA  out  32  Read data; valid only when PREADY=1 and PWRITE=0.
- PREADY  out  1  Transfer completes this cycle.
- PSLVERR  out  1  Error response; valid only when PREADY=1.
- o_wr_en  out  1  One-cycle pulse on a committed write.
- o_wr_idx  out  $clog2(NUM_REGS)  Register index of the committed write.
- o_wr_data  out  32  Data of the committed write.
- o_err_count  out  8  Saturating count of error responses.

Behaviour:
- Reset (i_reset=1 at an edge):
  - All outputs go to 0; every register goes to 0; state goes to IDLE; wait counter goes to 0.
  - Reset overrides any transfer in progress; an aborted write never commits.
- Registered outputs: PRDATA, PREADY, PSLVERR, o_wr_* and o_err_count are all registers.
- States: IDLE, ACCESS, DONE.
  - IDLE:
    - An edge with PSELx=1 and PENABLE=0 is a setup cycle: capture PADDR, PWRITE and PWDATA, and evaluate the error condition.
    - Move to ACCESS with counter = WAIT_STATES.
    - If WAIT_STATES=0, also set PREADY<=1 together with PRDATA/PSLVERR, so the first access cycle completes. Zero-wait-state transfers therefore take 2 cycles.
  - ACCESS:
    - If PSELx=0, the master has aborted: clear outputs, go to IDLE, commit nothing.
    - When PREADY=1 and PSELx&PENABLE at the edge, the transfer completes:
      - For a write without error, update the register and pulse o_wr_en for 1 cycle.
      - If PSLVERR, increment o_err_count, saturating at 255.
      - Clear PREADY, PSLVERR and PRDATA; go to DONE.
    - While PREADY=0, decrement the counter each edge. When the counter equals 1 (or is 0 while not ready), set PREADY<=1 with PRDATA/PSLVERR on the next edge.
    - Total access-phase length is WAIT_STATES+1 cycles.
  - DONE:
    - Lasts one cycle and returns to IDLE.
    - If DONE sees a setup cycle (PSELx=1, PENABLE=0), treat it exactly as IDLE would. Back-to-back transfers carry no bubble.
- Error condition:
  - PADDR[1:0] != 0, or
  - word index PADDR[31:2] >= NUM_REGS, or
  - PADDR == FORBIDDEN_ADDR.
- On error:
  - Writes do not modify any register and do not pulse o_wr_en.
  - Reads return PRDATA = 0.
- Read data: PRDATA = reg[PADDR[2+:IDXW]], sampled at the cycle PREADY is set.
- Address/control changes during ACCESS: the values captured at setup are used; later changes on the bus are ignored.
- Outside a completing cycle, PRDATA=0 and PSLVERR=0.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF to 0x08, then read 0x08.
  - Write: PREADY high in the first access cycle; o_wr_en pulses with idx=2.
  - Read: PRDATA=0xDEADBEEF, PSLVERR=0.
- WAIT_STATES=3: read 0x04 after a reset.
  - PREADY=0 for exactly 3 access cycles and high on the 4th.
  - PRDATA=0.
- Errors with NUM_REGS=16:
  - Write to 0x40 (out of range): PSLVERR=1, no o_wr_en, reg contents unchanged.
  - Read from 0x06 (misaligned): PSLVERR=1, PRDATA=0.
  - o_err_count=2 after both.
- Forbidden address with NUM_REGS=256:
  - Write to 0xCACA → PSLVERR=1.
  - Write to 0x0C → accepted.
- Abort and reset:
  - WAIT_STATES=4 write to 0x10 with PSELx dropped in the 2nd access cycle → no commit; a read of 0x10 returns 0.
  - i_reset asserted mid-transfer → all outputs 0 the next cycle.
- Back-to-back transfers:
  - Writes to 0x00, 0x04, 0x08 with no idle cycles → three o_wr_en pulses with idx 0, 1, 2.
  - A subsequent read of each returns the written value.
